// File: rtl/data_memory_bank_if.sv
// Request/response bundle between the MEM stage and the data memory bank.
// The master drives load/store requests; the slave returns load data and error pulses.
interface data_memory_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  memoryRead;
  logic                  memoryWrite;
  logic [1:0]            accessSize;
  logic                  signedLoad;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readValid;
  logic                  misaligned;
  logic                  rangeError;
  logic                  errorSticky;

  modport master (
    output memoryRead, memoryWrite, accessSize, signedLoad, address, writeData,
    input  readData, readValid, misaligned, rangeError, errorSticky
  );

  modport slave (
    input  memoryRead, memoryWrite, accessSize, signedLoad, address, writeData,
    output readData, readValid, misaligned, rangeError, errorSticky
  );
endinterface

// File: rtl/data_memory_bank.sv
// Byte-addressed, word-organised data RAM for the MEM stage with lane-masked stores,
// sign/zero-extended loads, a READ_LATENCY-deep read pipeline and error flagging.
module data_memory_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              resetN,
  data_memory_bank_if.slave bus
);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int L    = READ_LATENCY;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [1:0]  written_q;

  logic            rd_vld_q  [L];
  logic [31:0]     rd_data_q [L];
  logic            rd_mis_q  [L];
  logic            rd_rng_q  [L];
  logic            wr_mis_q;
  logic            wr_rng_q;
  logic            sticky_q;

  logic [IDXW-1:0]       idx;
  logic [1:0]            lane;
  logic [1:0]            sz;
  logic                  rd;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] hi_bits;
  logic                  mis_d;
  logic                  rng_d;
  logic                  err_d;
  logic                  we;
  logic [31:0]           cur_word;
  logic [31:0]           wr_rep;
  logic [31:0]           wr_mask;
  logic                  mis_o;
  logic                  rng_o;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'b00:   return 4'b0001 << ln;
      2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] ln,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      2'b10:   return word;
      default: return '0;
    endcase
  endfunction

  assign idx     = bus.address[IDXW+1:2];
  assign lane    = bus.address[1:0];
  assign sz      = bus.accessSize;
  assign rd      = bus.memoryRead;
  assign wr      = bus.memoryWrite;
  assign hi_bits = bus.address >> (IDXW + 2);

  // Simultaneous read and write is illegal and reported as a range error.
  assign mis_d = (rd || wr) && ((sz == 2'b01 && lane[0]) || (sz == 2'b10 && lane != 2'b00));
  assign rng_d = (rd || wr) && ((|hi_bits) || sz == 2'b11 || (rd && wr));
  assign err_d = mis_d || rng_d;
  assign we    = wr && !rd && !err_d;

  // Words 0 and 1 read as their power-up constants until first written.
  always_comb begin
    cur_word = mem_q[idx];
    if (idx == '0 && !written_q[0])
      cur_word = 32'h0000_0000;
    if (idx == IDXW'(1) && !written_q[1])
      cur_word = 32'h0000_0001;
  end

  always_comb begin
    wr_rep  = replicate_store(sz, bus.writeData);
    wr_mask = '0;
    for (int i = 0; i < 4; i++)
      wr_mask[8*i +: 8] = {8{lane_enables(sz, lane)[i]}};
  end

  always_ff @(posedge clock) begin
    if (we)
      mem_q[idx] <= (cur_word & ~wr_mask) | (wr_rep & wr_mask);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      written_q <= '0;
    end else if (we && idx == '0) begin
      written_q[0] <= 1'b1;
    end else if (we && idx == IDXW'(1)) begin
      written_q[1] <= 1'b1;
    end
  end

  // Read pipeline: stage 0 captures the extended word, later stages shift it out.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < L; k++) begin
        rd_vld_q[k]  <= 1'b0;
        rd_data_q[k] <= '0;
        rd_mis_q[k]  <= 1'b0;
        rd_rng_q[k]  <= 1'b0;
      end
      wr_mis_q <= 1'b0;
      wr_rng_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rd_vld_q[0] <= rd;
      rd_mis_q[0] <= rd && mis_d;
      rd_rng_q[0] <= rd && rng_d;
      if (rd)
        rd_data_q[0] <= err_d ? '0 : extend_load(cur_word, lane, sz, bus.signedLoad);
      for (int k = 1; k < L; k++) begin
        rd_vld_q[k] <= rd_vld_q[k-1];
        rd_mis_q[k] <= rd_mis_q[k-1];
        rd_rng_q[k] <= rd_rng_q[k-1];
        if (rd_vld_q[k-1])
          rd_data_q[k] <= rd_data_q[k-1];
      end
      wr_mis_q <= wr && !rd && mis_d;
      wr_rng_q <= wr && !rd && rng_d;
      sticky_q <= sticky_q || mis_o || rng_o;
    end
  end

  assign mis_o           = rd_mis_q[L-1] || wr_mis_q;
  assign rng_o           = rd_rng_q[L-1] || wr_rng_q;
  assign bus.readValid   = rd_vld_q[L-1];
  assign bus.readData    = rd_data_q[L-1];
  assign bus.misaligned  = mis_o;
  assign bus.rangeError  = rng_o;
  assign bus.errorSticky = sticky_q || mis_o || rng_o;
endmodule

// File: tb/tb_data_memory_bank.sv
// Randomised and directed bench for data_memory_bank with a byte-level reference memory
// and a queue-based scoreboard checked by an independent monitor.
module tb_data_memory_bank;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;
  localparam int AW    = 32;

  logic clock  = 1'b0;
  logic resetN = 1'b1;
  always #5 clock = ~clock;

  data_memory_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  data_memory_bank #(
    .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       tag;
  } rsp_t;

  rsp_t        rq[$];
  bit          exp_mis[int];
  bit          exp_rng[int];
  logic [31:0] mdl[int];
  bit          sticky_m  = 0;
  bit          mon_en    = 0;
  logic [31:0] last_data = '0;
  int          checks    = 0;
  int          errors    = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  bit   em, er;
  rsp_t r;
  always @(negedge clock) begin
    if (mon_en) begin
      if (!resetN) begin
        check("reset readValid", 32'(bus.readValid), 0);
        check("reset readData", bus.readData, 0);
        check("reset misaligned", 32'(bus.misaligned), 0);
        check("reset rangeError", 32'(bus.rangeError), 0);
        check("reset errorSticky", 32'(bus.errorSticky), 0);
      end else begin
        em = exp_mis.exists(cyc) ? exp_mis[cyc] : 1'b0;
        er = exp_rng.exists(cyc) ? exp_rng[cyc] : 1'b0;
        check("misaligned", 32'(bus.misaligned), 32'(em));
        check("rangeError", 32'(bus.rangeError), 32'(er));
        if (em || er) sticky_m = 1'b1;
        check("errorSticky", 32'(bus.errorSticky), 32'(sticky_m));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          check({"readValid ", r.tag}, 32'(bus.readValid), 1);
          check({"readData ", r.tag}, bus.readData, r.data);
          last_data = r.data;
        end else begin
          check("readValid idle", 32'(bus.readValid), 0);
          check("readData hold", bus.readData, last_data);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.memoryRead  = 1'b0;
    bus.memoryWrite = 1'b0;
    bus.accessSize  = 2'b10;
    bus.signedLoad  = 1'b0;
    bus.address     = '0;
    bus.writeData   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      drive_idle();
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    mon_en = 1'b1;
    resetN = 1'b0;
    drive_idle();
    rq.delete();
    exp_mis.delete();
    exp_rng.delete();
    sticky_m  = 1'b0;
    last_data = '0;
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  task automatic mark(input int due, input bit m, input bit g);
    exp_mis[due] = (exp_mis.exists(due) ? exp_mis[due] : 1'b0) | m;
    exp_rng[due] = (exp_rng.exists(due) ? exp_rng[due] : 1'b0) | g;
  endtask

  // Issue one request; the reference memory is updated and the response predicted.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit lit_en, input logic [31:0] lit, input string tag);
    int          k, nb, w, ln;
    bit          mis, rng;
    logic [31:0] tmp, val;
    rsp_t        e;
    @(posedge clock); #1;
    bus.memoryRead  = rd;
    bus.memoryWrite = wr;
    bus.accessSize  = sz;
    bus.signedLoad  = sg;
    bus.address     = a;
    bus.writeData   = wd;
    k   = cyc;
    nb  = 1 << sz;
    w   = int'(a >> 2);
    ln  = int'(a % 4);
    mis = (rd || wr) && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && (a % 4) != 0));
    rng = (rd || wr) && (a >= DEPTH * 4 || sz == 2'd3 || (rd && wr));
    if (wr && !rd && !mis && !rng) begin
      tmp = mdl.exists(w) ? mdl[w] : 32'h0;
      for (int i = 0; i < nb; i++) tmp[8*(ln+i) +: 8] = wd[8*i +: 8];
      mdl[w] = tmp;
    end
    if (rd) begin
      val = '0;
      if (!mis && !rng) begin
        for (int i = 0; i < nb; i++) val[8*i +: 8] = mdl[w][8*(ln+i) +: 8];
        if (sg && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 1);
      end
      e.due  = k + LAT;
      e.data = lit_en ? lit : val;
      e.tag  = tag;
      rq.push_back(e);
      mark(k + LAT, mis, rng);
    end else if (wr) begin
      mark(k + 1, mis, rng);
    end
  endtask

  task automatic ld(input logic [1:0] sz, input bit sg, input logic [31:0] a,
                    input logic [31:0] lit, input string tag);
    issue(1'b1, 1'b0, sz, sg, a, 32'h0, 1'b1, lit, tag);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    issue(1'b0, 1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, "store");
  endtask

  logic [1:0]  rsz;
  logic [31:0] raddr;
  int          sel;

  initial begin
    drive_idle();
    mdl[0] = 32'h0000_0000;
    mdl[1] = 32'h0000_0001;
    do_reset();
    idle(2);

    ld(2'd2, 1'b0, 32'h4, 32'h0000_0001, "lw power-up word1");
    ld(2'd2, 1'b0, 32'h0, 32'h0000_0000, "lw power-up word0");

    st(2'd2, 32'h10, 32'hAABB_CCDD);
    st(2'd0, 32'h12, 32'h0000_0011);
    ld(2'd2, 1'b0, 32'h10, 32'hAA11_CCDD, "lw after sb");
    ld(2'd0, 1'b1, 32'h13, 32'hFFFF_FFAA, "lb signed");
    ld(2'd0, 1'b0, 32'h13, 32'h0000_00AA, "lbu");
    ld(2'd1, 1'b1, 32'h12, 32'hFFFF_AA11, "lh signed");
    ld(2'd1, 1'b0, 32'h12, 32'h0000_AA11, "lhu");
    idle(LAT + 2);

    ld(2'd2, 1'b0, 32'h0E, 32'h0, "lw misaligned");
    ld(2'd1, 1'b1, 32'h11, 32'h0, "lh misaligned");
    ld(2'd2, 1'b0, DEPTH * 4, 32'h0, "lw out of range");
    st(2'd2, 32'h12, 32'hDEAD_BEEF);
    st(2'd2, 32'h8000_0010, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, "reserved size");
    ld(2'd2, 1'b0, 32'h10, 32'hAA11_CCDD, "reread after errors");
    idle(LAT + 2);

    st(2'd2, 32'h20, 32'h1234_5678);
    issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0, "read+write");
    ld(2'd2, 1'b0, 32'h20, 32'h1234_5678, "word after read+write");
    idle(LAT + 2);

    ld(2'd2, 1'b0, 32'h0,  32'h0000_0000, "burst0");
    ld(2'd2, 1'b0, 32'h4,  32'h0000_0001, "burst1");
    ld(2'd2, 1'b0, 32'h10, 32'hAA11_CCDD, "burst2");
    ld(2'd2, 1'b0, 32'h20, 32'h1234_5678, "burst3");
    idle(LAT + 2);

    ld(2'd2, 1'b0, 32'h10, 32'hAA11_CCDD, "flushed0");
    ld(2'd2, 1'b0, 32'h20, 32'h1234_5678, "flushed1");
    do_reset();
    idle(LAT + 3);

    for (int i = 0; i < DEPTH; i++) st(2'd2, 32'(i * 4), $urandom);
    for (int n = 0; n < 300; n++) begin
      sel   = int'($urandom_range(0, 9));
      rsz   = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      raddr = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 15) == 0)
        raddr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(DEPTH * 4, 1023)) : 32'h8000_0010;
      if (sel <= 3)
        issue(1'b1, 1'b0, rsz, 1'($urandom_range(0, 1)), raddr, 32'h0, 1'b0, 32'h0, "rnd load");
      else if (sel <= 7)
        issue(1'b0, 1'b1, rsz, 1'b0, raddr, $urandom, 1'b0, 32'h0, "rnd store");
      else if (sel == 8)
        idle(1);
      else
        issue(1'b1, 1'b1, rsz, 1'b0, raddr, $urandom, 1'b0, 32'h0, "rnd read+write");
    end
    idle(LAT + 3);

    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL pending responses: got %0d outstanding expected 0", rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
